// File: rtl/rf_pkg.sv
// Shared defaults, address-width helper and data/address typedefs for the rf family.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    function automatic int unsigned aw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [aw(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]      xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on producer issue, cleared by writeback; set beats clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NRD    = 2,
    parameter  int unsigned NWR    = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] reg_s,
    output logic [NRD-1:0]    busy_s,
    input  logic [NWR*AW-1:0] rd,
    input  logic [NWR-1:0]    wr_ok,
    input  logic              busy_set_e,
    input  logic [AW-1:0]     busy_set_rd
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             set_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    assign set_ok = busy_set_e && addr_ok(busy_set_rd);

    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (wr_ok[j] && rd[j*AW +: AW] == AW'(r)) busy_d[r] = 1'b0;
            end
        end
        if (set_ok) busy_d[busy_set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Bypass view: a writeback landing this cycle already retires the pending mark,
    // unless a newer producer is being issued to the same register.
    always_comb begin
        busy_s = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          clr;
            a   = reg_s[i*AW +: AW];
            clr = 1'b0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_ok[j] && rd[j*AW +: AW] == a) clr = 1'b1;
            end
            if (rst_n && addr_ok(a)) begin
                busy_s[i] = busy_q[a];
                if (BYPASS != 0 && clr && !(set_ok && busy_set_rd == a)) busy_s[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with x0 hardwired to zero, write-port priority, optional
// same-cycle write->read bypass and a pending-writeback scoreboard.
module rf_mp
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NRD    = 2,
    parameter  int unsigned NWR    = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   reg_s,
    output logic [NRD*XLEN-1:0] reg_d,
    output logic [NRD-1:0]      busy_s,
    input  logic [NWR*AW-1:0]   rd,
    input  logic [NWR-1:0]      write_e,
    input  logic [NWR*XLEN-1:0] write_d,
    input  logic                busy_set_e,
    input  logic [AW-1:0]       busy_set_rd
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NWR-1:0]  wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    always_comb begin
        for (int unsigned j = 0; j < NWR; j++) begin
            wr_ok[j] = write_e[j] && addr_ok(rd[j*AW +: AW]);
        end
    end

    // Ascending port scan: later (higher-index) ports overwrite earlier ones.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) mem_d[r] = mem_q[r];
        for (int unsigned j = 0; j < NWR; j++) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (wr_ok[j] && rd[j*AW +: AW] == AW'(r)) mem_d[r] = write_d[j*XLEN +: XLEN];
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        reg_d = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] rdata;
            a     = reg_s[i*AW +: AW];
            rdata = '0;
            if (rst_n && addr_ok(a)) begin
                rdata = mem_q[a];
                if (BYPASS != 0) begin
                    for (int unsigned j = 0; j < NWR; j++) begin
                        if (wr_ok[j] && rd[j*AW +: AW] == a) rdata = write_d[j*XLEN +: XLEN];
                    end
                end
            end
            reg_d[i*XLEN +: XLEN] = rdata;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_s       (reg_s),
        .busy_s      (busy_s),
        .rd          (rd),
        .wr_ok       (wr_ok),
        .busy_set_e  (busy_set_e),
        .busy_set_rd (busy_set_rd)
    );

endmodule

// File: tb/tb_rf_mp.sv
// Scoreboard bench for rf_mp: default (bypass), BYPASS=0 and a 64-bit/24-reg/3R1W variant,
// checked against an array-level reference model of the register-file rules.
module tb_rf_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A (default) and B (BYPASS=0) share every input; C is the swept configuration.
    logic [9:0]   reg_s_ab;
    logic [63:0]  reg_d_a, reg_d_b;
    logic [1:0]   busy_a, busy_b;
    logic [9:0]   rd_ab;
    logic [1:0]   we_ab;
    logic [63:0]  wd_ab;
    logic         bse_ab;
    logic [4:0]   bsrd_ab;
    logic [14:0]  reg_s_c;
    logic [191:0] reg_d_c;
    logic [2:0]   busy_c;
    logic [4:0]   rd_c;
    logic [0:0]   we_c;
    logic [63:0]  wd_c;
    logic         bse_c;
    logic [4:0]   bsrd_c;

    rf_mp u_a (
        .clk(clk), .rst_n(rst_n), .reg_s(reg_s_ab), .reg_d(reg_d_a), .busy_s(busy_a),
        .rd(rd_ab), .write_e(we_ab), .write_d(wd_ab), .busy_set_e(bse_ab), .busy_set_rd(bsrd_ab)
    );

    rf_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .reg_s(reg_s_ab), .reg_d(reg_d_b), .busy_s(busy_b),
        .rd(rd_ab), .write_e(we_ab), .write_d(wd_ab), .busy_set_e(bse_ab), .busy_set_rd(bsrd_ab)
    );

    rf_mp #(.XLEN(64), .NREGS(24), .NRD(3), .NWR(1), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .reg_s(reg_s_c), .reg_d(reg_d_c), .busy_s(busy_c),
        .rd(rd_c), .write_e(we_c), .write_d(wd_c), .busy_set_e(bse_c), .busy_set_rd(bsrd_c)
    );

    int unsigned NR [3] = '{32, 32, 24};
    int unsigned NP [3] = '{2, 2, 3};
    int unsigned NW [3] = '{2, 2, 1};
    bit          BY [3] = '{1'b1, 1'b0, 1'b1};

    logic [63:0] mem  [3][32];
    bit          busy [3][32];
    int unsigned rs   [3][3];
    int unsigned wa   [3][2];
    bit          we   [3][2];
    logic [63:0] wd   [3][2];
    bit          bse  [3];
    int unsigned bsa  [3];
    bit          rst_v;

    typedef struct {
        int          dut;
        logic [63:0] d [3];
        logic [2:0]  b;
    } exp_t;
    exp_t sbq [$];

    int checks = 0;
    int errors = 0;

    function automatic bit valid(int d, int unsigned a);
        return a != 0 && a < NR[d];
    endfunction

    function automatic bit written(int d, int unsigned a);
        for (int j = 0; j < NW[d]; j++) if (we[d][j] && wa[d][j] == a && valid(d, a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] winner(int d, int unsigned a);
        for (int j = NW[d] - 1; j >= 0; j--) if (we[d][j] && wa[d][j] == a) return wd[d][j];
        return 64'd0;
    endfunction

    function automatic logic [63:0] exp_read(int d, int i);
        int unsigned a = rs[d][i];
        if (!rst_v || !valid(d, a)) return 64'd0;
        if (BY[d] && written(d, a)) return winner(d, a);
        return mem[d][a];
    endfunction

    function automatic logic exp_busy(int d, int i);
        int unsigned a = rs[d][i];
        if (!rst_v || !valid(d, a)) return 1'b0;
        if (BY[d] && written(d, a) && !(bse[d] && bsa[d] == a)) return 1'b0;
        return busy[d][a];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 32; r++) begin
                mem[d][r]  = 64'd0;
                busy[d][r] = 1'b0;
            end
    endtask

    task automatic commit();
        if (!rst_v) begin
            clear_model();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            for (int unsigned r = 1; r < NR[d]; r++) begin
                if (written(d, r)) begin
                    mem[d][r]  = winner(d, r);
                    busy[d][r] = 1'b0;
                end
            end
            if (bse[d] && valid(d, bsa[d])) busy[d][bsa[d]] = 1'b1;
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            for (int j = 0; j < 2; j++) we[d][j] = 1'b0;
            bse[d] = 1'b0;
        end
    endtask

    // Drive pins from the model inputs and queue the expected response.
    task automatic drive_push();
        exp_t e;
        for (int i = 0; i < 3; i++) rs[1][i] = rs[0][i];
        for (int j = 0; j < 2; j++) begin
            wa[1][j] = wa[0][j]; we[1][j] = we[0][j]; wd[1][j] = wd[0][j];
        end
        bse[1] = bse[0]; bsa[1] = bsa[0];
        for (int i = 0; i < 2; i++) reg_s_ab[i*5 +: 5] = 5'(rs[0][i]);
        for (int j = 0; j < 2; j++) begin
            rd_ab[j*5 +: 5]  = 5'(wa[0][j]);
            we_ab[j]         = we[0][j];
            wd_ab[j*32 +: 32] = wd[0][j][31:0];
        end
        bse_ab  = bse[0];
        bsrd_ab = 5'(bsa[0]);
        for (int i = 0; i < 3; i++) reg_s_c[i*5 +: 5] = 5'(rs[2][i]);
        rd_c    = 5'(wa[2][0]);
        we_c[0] = we[2][0];
        wd_c    = wd[2][0];
        bse_c   = bse[2];
        bsrd_c  = 5'(bsa[2]);
        rst_n   = rst_v;
        if (!rst_v) clear_model();
        for (int d = 0; d < 3; d++) begin
            e.dut = d;
            e.b   = '0;
            for (int i = 0; i < 3; i++) begin
                e.d[i] = (i < NP[d]) ? exp_read(d, i) : 64'd0;
                if (i < NP[d]) e.b[i] = exp_busy(d, i);
            end
            sbq.push_back(e);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic dchk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] act_d(int d, int i);
        case (d)
            0:       return {32'd0, reg_d_a[i*32 +: 32]};
            1:       return {32'd0, reg_d_b[i*32 +: 32]};
            default: return reg_d_c[i*64 +: 64];
        endcase
    endfunction

    function automatic logic act_b(int d, int i);
        case (d)
            0:       return busy_a[i];
            1:       return busy_b[i];
            default: return busy_c[i];
        endcase
    endfunction

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            for (int i = 0; i < NP[e.dut]; i++) begin
                checks++;
                if (act_d(e.dut, i) !== e.d[i]) begin
                    errors++;
                    $display("FAIL sb_data dut%0d port%0d: got %h expected %h", e.dut, i, act_d(e.dut, i), e.d[i]);
                end
                checks++;
                if (act_b(e.dut, i) !== e.b[i]) begin
                    errors++;
                    $display("FAIL sb_busy dut%0d port%0d: got %b expected %b", e.dut, i, act_b(e.dut, i), e.b[i]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_model();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 3; i++) rs[d][i] = 0;
            for (int j = 0; j < 2; j++) begin wa[d][j] = 0; wd[d][j] = 64'd0; end
            bsa[d] = 0;
        end
        idle();
        rst_v = 1'b0;
        @(posedge clk); #1;
        repeat (3) begin drive_push(); tick(); end
        rst_v = 1'b1;

        // Basic write/read and x0
        idle(); we[0][0] = 1; wa[0][0] = 4; wd[0][0] = 64'd42; drive_push(); tick();
        idle(); rs[0][0] = 4; rs[0][1] = 0; drive_push();
        dchk("basic_x4", reg_d_a[31:0], 64'd42);
        dchk("basic_x0", reg_d_a[63:32], 64'd0);
        tick();
        idle(); we[0][0] = 1; wa[0][0] = 0; wd[0][0] = 64'd5; rs[0][0] = 0; drive_push(); tick();
        idle(); drive_push(); dchk("x0_after_write", reg_d_a[31:0], 64'd0); tick();

        // Port priority
        idle(); we[0][0] = 1; wa[0][0] = 3; wd[0][0] = 64'd11;
        we[0][1] = 1; wa[0][1] = 3; wd[0][1] = 64'd22; drive_push(); tick();
        idle(); rs[0][0] = 3; drive_push(); dchk("priority_x3", reg_d_a[31:0], 64'd22); tick();

        // Bypass vs stored read
        idle(); we[0][0] = 1; wa[0][0] = 7; wd[0][0] = 64'd99; rs[0][0] = 7; drive_push();
        dchk("bypass_on", reg_d_a[31:0], 64'd99);
        dchk("bypass_off_old", reg_d_b[31:0], 64'd0);
        tick();
        idle(); drive_push(); dchk("bypass_off_new", reg_d_b[31:0], 64'd99); tick();

        // Scoreboard
        idle(); bse[0] = 1; bsa[0] = 9; rs[0][0] = 9; drive_push();
        dchk("busy_before_set", 64'(busy_a[0]), 64'd0); tick();
        idle(); drive_push();
        dchk("busy_set_a", 64'(busy_a[0]), 64'd1);
        dchk("busy_set_b", 64'(busy_b[0]), 64'd1); tick();
        idle(); we[0][1] = 1; wa[0][1] = 9; wd[0][1] = 64'd1; drive_push();
        dchk("busy_masked_a", 64'(busy_a[0]), 64'd0);
        dchk("busy_unmasked_b", 64'(busy_b[0]), 64'd1); tick();
        idle(); drive_push();
        dchk("busy_cleared_a", 64'(busy_a[0]), 64'd0);
        dchk("busy_cleared_b", 64'(busy_b[0]), 64'd0); tick();
        idle(); bse[0] = 1; bsa[0] = 9; we[0][0] = 1; wa[0][0] = 9; wd[0][0] = 64'd2; drive_push(); tick();
        idle(); drive_push(); dchk("set_beats_clear", 64'(busy_a[0]), 64'd1); tick();

        // Swept configuration
        idle(); we[2][0] = 1; wa[2][0] = 23; wd[2][0] = 64'hDEADBEEF_CAFEF00D; drive_push(); tick();
        idle(); rs[2][0] = 23; drive_push(); dchk("c_x23", reg_d_c[63:0], 64'hDEADBEEF_CAFEF00D); tick();
        idle(); we[2][0] = 1; wa[2][0] = 30; wd[2][0] = 64'h123; rs[2][1] = 30; rs[2][2] = 6; drive_push();
        dchk("c_read30_bypass", reg_d_c[127:64], 64'd0); tick();
        idle(); drive_push();
        dchk("c_read30", reg_d_c[127:64], 64'd0);
        dchk("c_no_alias_x6", reg_d_c[191:128], 64'd0); tick();

        // Reset mid-operation
        idle(); we[0][0] = 1; wa[0][0] = 5; wd[0][0] = 64'd7; drive_push(); tick();
        idle(); bse[0] = 1; bsa[0] = 5; rs[0][0] = 5; drive_push(); tick();
        idle(); drive_push();
        dchk("pre_reset_x5", reg_d_a[31:0], 64'd7);
        dchk("pre_reset_busy", 64'(busy_a[0]), 64'd1); tick();
        rst_v = 1'b0; we[0][0] = 1; wa[0][0] = 5; wd[0][0] = 64'd8; drive_push();
        dchk("in_reset_x5", reg_d_a[31:0], 64'd0);
        dchk("in_reset_busy", 64'(busy_a[0]), 64'd0); tick();
        rst_v = 1'b1; idle(); drive_push();
        dchk("post_reset_x5", reg_d_a[31:0], 64'd0);
        dchk("post_reset_busy", 64'(busy_a[0]), 64'd0); tick();

        // Randomised traffic, addresses biased toward a small set to force collisions
        for (int n = 0; n < 400; n++) begin
            rst_v = ($urandom_range(0, 59) != 0);
            for (int d = 0; d < 3; d += 2) begin
                for (int i = 0; i < 3; i++)
                    rs[d][i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
                for (int j = 0; j < 2; j++) begin
                    we[d][j] = ($urandom_range(0, 1) == 1);
                    wa[d][j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
                    wd[d][j] = (d == 0) ? {32'd0, 32'($urandom)} : {32'($urandom), 32'($urandom)};
                end
                bse[d] = ($urandom_range(0, 2) == 0);
                bsa[d] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            end
            drive_push();
            tick();
        end

        idle(); rst_v = 1'b1; drive_push(); tick();
        @(negedge clk); #1;
        dchk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
